// File: rtl/spi_pkg.sv
// Shared encodings for the SPI requester arbiter: FSM states, mode bits, byte width.
package spi_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned MODE_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_rr_pick.sv
// Round-robin encoder: first set request at or after ptr, wrapping at NUM_REQ.
module spi_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      grant_idx_c,
    output logic               grant_vld_c
);

    always_comb begin
        int j;
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        j           = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            j = int'(ptr) + i;
            if (j >= int'(NUM_REQ)) j = j - int'(NUM_REQ);
            if (!grant_vld_c && req[j[IW-1:0]]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = IW'(j);
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin sharing of one SPI byte engine between NUM_REQ clients, with
// chip-select ownership, setup/gap timing, burst hold and timeout abort.
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned TIMEOUT      = 1023
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
    input  logic [MODE_W*NUM_REQ-1:0]   req_mode,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        err,
    output logic [BYTE_W-1:0]           rd_data,
    output logic [NUM_REQ-1:0]          cs_n,
    output logic                        m_start,
    output logic [BYTE_W-1:0]           m_data_wr,
    output logic                        m_polarity,
    output logic                        m_phase,
    input  logic                        m_done,
    input  logic [BYTE_W-1:0]           m_data_rd,
    output logic                        busy
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(SETUP_CYCLES + GAP_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_t              state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [IW-1:0]       rr_q, rr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic                last_q, last_d;
    spi_mode_t           mode_q, mode_d;
    logic [BYTE_W-1:0]   data_d, rd_data_d;
    logic [NUM_REQ-1:0]  ack_d, cs_n_d;
    logic                err_d, m_start_d, busy_d;
    logic [IW-1:0]       pick_idx_c;
    logic                pick_vld_c;

    logic [BYTE_W-1:0]   data_arr [NUM_REQ];
    spi_mode_t           mode_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*BYTE_W +: BYTE_W];
        assign mode_arr[g] = spi_mode_t'(req_mode[g*MODE_W +: MODE_W]);
    end

    spi_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req         (req),
        .ptr         (rr_q),
        .grant_idx_c (pick_idx_c),
        .grant_vld_c (pick_vld_c)
    );

    assign m_polarity = mode_q.cpol;
    assign m_phase    = mode_q.cpha;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; HOLD waits one cycle after ack so the client can update req
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_vld_c) state_d = ST_SETUP;
            ST_SETUP: if (cnt_q == CW'(SETUP_CYCLES - 1)) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (m_done)                             state_d = last_q ? ST_GAP : ST_HOLD;
                else if (tcnt_q == TW'(TIMEOUT - 1))    state_d = ST_GAP;
            end
            ST_HOLD:  if (ack == '0) state_d = req[owner_q] ? ST_START : ST_GAP;
            ST_GAP:   if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        owner_d   = owner_q;
        rr_d      = rr_q;
        last_d    = last_q;
        mode_d    = mode_q;
        data_d    = m_data_wr;
        rd_data_d = rd_data;
        ack_d     = '0;
        err_d     = 1'b0;
        cnt_d     = (state_d == state_q) ? cnt_q + CW'(1) : '0;
        tcnt_d    = (state_q == ST_WAIT) ? tcnt_q + TW'(1) : '0;
        case (state_q)
            ST_IDLE: if (pick_vld_c) begin
                owner_d = pick_idx_c;
                last_d  = req_last[pick_idx_c];
                mode_d  = mode_arr[pick_idx_c];
                data_d  = data_arr[pick_idx_c];
            end
            ST_WAIT: begin
                if (m_done) begin
                    rd_data_d      = m_data_rd;
                    ack_d[owner_q] = 1'b1;
                end else if (state_d == ST_GAP) begin
                    rd_data_d      = '0;
                    ack_d[owner_q] = 1'b1;
                    err_d          = 1'b1;
                end
            end
            ST_HOLD: if (state_d == ST_START) begin
                last_d = req_last[owner_q];
                data_d = data_arr[owner_q];
            end
            ST_GAP: if (state_d == ST_IDLE) begin
                rr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
            end
            default: ;
        endcase
        m_start_d = (state_d == ST_START);
        busy_d    = (state_d != ST_IDLE);
        cs_n_d    = '1;
        if (state_d inside {ST_SETUP, ST_START, ST_WAIT, ST_HOLD}) cs_n_d[owner_d] = 1'b0;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q   <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            last_q    <= 1'b0;
            mode_q    <= '0;
            m_data_wr <= '0;
            rd_data   <= '0;
            ack       <= '0;
            err       <= 1'b0;
            cs_n      <= '1;
            m_start   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            last_q    <= last_d;
            mode_q    <= mode_d;
            m_data_wr <= data_d;
            rd_data   <= rd_data_d;
            ack       <= ack_d;
            err       <= err_d;
            cs_n      <= cs_n_d;
            m_start   <= m_start_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: the bench plays both the clients and the SPI byte engine.
module tb_spi_arbiter;

    localparam int unsigned SU = 2;
    localparam int unsigned GP = 4;
    localparam int unsigned TO = 1023;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [7:0]  req_mode;
    logic [3:0]  req_last;
    logic [3:0]  ack;
    logic        err;
    logic [7:0]  rd_data;
    logic [3:0]  cs_n;
    logic        m_start;
    logic [7:0]  m_data_wr;
    logic        m_polarity;
    logic        m_phase;
    logic        m_done;
    logic [7:0]  m_data_rd;
    logic        busy;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_start  = 0;
    logic cs_multi = 1'b0;

    spi_arbiter #(.NUM_REQ(4), .SETUP_CYCLES(SU), .GAP_CYCLES(GP), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .req_mode   (req_mode),
        .req_last   (req_last),
        .ack        (ack),
        .err        (err),
        .rd_data    (rd_data),
        .cs_n       (cs_n),
        .m_start    (m_start),
        .m_data_wr  (m_data_wr),
        .m_polarity (m_polarity),
        .m_phase    (m_phase),
        .m_done     (m_done),
        .m_data_rd  (m_data_rd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (m_start === 1'b1) n_start <= n_start + 1;
    always @(negedge clk) if ($countones(~cs_n) > 1) cs_multi <= 1'b1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic [1:0] m, input logic l);
        req_data[i*8 +: 8] = d;
        req_mode[i*2 +: 2] = m;
        req_last[i]        = l;
        req[i]             = 1'b1;
    endtask

    task automatic wait_start(input string tag, output int n);
        n = 0;
        while (m_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start"}, 32'(m_start), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    // Wait for m_start, check grant, answer after dly cycles, check the ack
    task automatic serve(input string tag, input int who, input logic [7:0] tx,
                         input logic [7:0] rx, input int dly, output int n);
        logic [3:0] eack, ecs;
        eack = 4'b0001 << who;
        ecs  = ~eack;
        wait_start(tag, n);
        check({tag, "_cs"}, 32'(cs_n), 32'(ecs));
        check({tag, "_tx"}, 32'(m_data_wr), 32'(tx));
        repeat (dly) @(negedge clk);
        m_done    = 1'b1;
        m_data_rd = rx;
        @(negedge clk);
        m_done    = 1'b0;
        m_data_rd = 8'h00;
        check({tag, "_ack"}, 32'(ack), 32'(eack));
        check({tag, "_rd"}, 32'(rd_data), 32'(rx));
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int   n, cnt, s0;
        int   order [6];
        logic gap_ok;

        order    = '{0, 1, 3, 0, 1, 3};
        req      = '0;
        req_data = '0;
        req_mode = '0;
        req_last = '0;
        m_done   = 1'b0;
        m_data_rd = '0;

        repeat (3) @(negedge clk);
        check("rst_cs", 32'(cs_n), 32'hF);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rd", 32'(rd_data), 32'h0);
        check("rst_start", 32'(m_start), 32'h0);
        check("rst_tx", 32'(m_data_wr), 32'h0);
        check("rst_mode", 32'({m_polarity, m_phase}), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Round robin over requesters 0,1,3 with req held throughout
        set_req(0, 8'h10, 2'b00, 1'b1);
        set_req(1, 8'h11, 2'b00, 1'b1);
        set_req(3, 8'h13, 2'b00, 1'b1);
        for (int k = 0; k < 6; k++) begin
            serve($sformatf("rr%0d", k), order[k], 8'(8'h10 + order[k]), 8'(8'hE0 + k), 2, n);
            if (k == 5) req = '0;
        end
        wait_idle("rr_idle");

        // Single byte on requester 0
        set_req(0, 8'hA5, 2'b00, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("sb_cs", 32'(cs_n), 32'hE);
                check("sb_busy", 32'(busy), 32'h1);
            end
        end while (m_start !== 1'b1 && n < 20);
        check("sb_latency", n, SU + 1);
        check("sb_tx", 32'(m_data_wr), 32'hA5);
        @(negedge clk);
        check("sb_pulse", 32'(m_start), 32'h0);
        m_done    = 1'b1;
        m_data_rd = 8'h3C;
        @(negedge clk);
        m_done = 1'b0;
        req    = '0;
        check("sb_ack", 32'(ack), 32'h1);
        check("sb_rd", 32'(rd_data), 32'h3C);
        check("sb_err", 32'(err), 32'h0);
        gap_ok = (cs_n === 4'hF);
        repeat (GP - 1) begin
            @(negedge clk);
            if (cs_n !== 4'hF) gap_ok = 1'b0;
        end
        check("sb_gap", 32'(gap_ok), 32'h1);
        @(negedge clk);
        check("sb_idle", 32'(busy), 32'h0);

        // Burst of three bytes on requester 2
        s0 = n_start;
        set_req(2, 8'h11, 2'b00, 1'b0);
        serve("b1", 2, 8'h11, 8'h91, 2, n);
        check("b1_lat", n, SU + 1);
        check("b1_hold_cs", 32'(cs_n), 32'hB);
        req_data[23:16] = 8'h22;
        serve("b2", 2, 8'h22, 8'h92, 1, n);
        check("b2_nosetup", n, 2);
        req_data[23:16] = 8'h33;
        req_last[2]     = 1'b1;
        serve("b3", 2, 8'h33, 8'h93, 3, n);
        check("b3_nosetup", n, 2);
        check("b3_gap", 32'(cs_n), 32'hF);
        req = '0;
        wait_idle("b_idle");
        check("b_starts", n_start - s0, 3);

        // Mode applied at grant, frozen for the rest of the frame
        set_req(1, 8'h5A, 2'b11, 1'b0);
        @(negedge clk);
        check("md_grant", 32'({m_polarity, m_phase}), 32'h3);
        serve("m1", 1, 8'h5A, 8'hA1, 2, n);
        req_mode[3:2]  = 2'b00;
        req_data[15:8] = 8'h6B;
        req_last[1]    = 1'b1;
        serve("m2", 1, 8'h6B, 8'hA2, 2, n);
        check("md_frozen", 32'({m_polarity, m_phase}), 32'h3);
        req = '0;
        wait_idle("m_idle");
        set_req(1, 8'h7C, 2'b01, 1'b1);
        @(negedge clk);
        check("md_new", 32'({m_polarity, m_phase}), 32'h1);
        serve("m3", 1, 8'h7C, 8'hA3, 2, n);
        req = '0;
        wait_idle("m3_idle");

        // Timeout on requester 0 (pointer sits at 2, so 0 wins over 1)
        set_req(0, 8'hC3, 2'b00, 1'b1);
        set_req(1, 8'hD4, 2'b00, 1'b1);
        wait_start("to", n);
        check("to_cs", 32'(cs_n), 32'hE);
        cnt = 0;
        while (ack === 4'h0 && cnt < 1100) begin
            @(negedge clk);
            cnt++;
        end
        check("to_cycles", cnt, TO + 1);
        check("to_ack", 32'(ack), 32'h1);
        check("to_err", 32'(err), 32'h1);
        check("to_rd", 32'(rd_data), 32'h0);
        check("to_cs_rel", 32'(cs_n), 32'hF);
        req[0] = 1'b0;
        // Requester 1 answered on the last cycle before timeout: done wins
        serve("edge", 1, 8'hD4, 8'h77, TO, n);
        req = '0;
        wait_idle("edge_idle");

        // Async reset while waiting on the engine
        set_req(2, 8'h99, 2'b00, 1'b1);
        wait_start("rst", n);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rw_cs", 32'(cs_n), 32'hF);
        check("rw_start", 32'(m_start), 32'h0);
        check("rw_busy", 32'(busy), 32'h0);
        req = '0;
        @(negedge clk);
        reset     = 1'b1;
        m_done    = 1'b1;
        m_data_rd = 8'h55;
        @(negedge clk);
        m_done = 1'b0;
        check("rw_late_ack", 32'(ack), 32'h0);
        check("rw_late_rd", 32'(rd_data), 32'h0);
        @(negedge clk);
        check("rw_late_busy", 32'(busy), 32'h0);
        check("rw_late_cs", 32'(cs_n), 32'hF);

        check("cs_onehot", 32'(cs_multi), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
Round-robin scheduler that shares one SPI byte engine (spi_master-class datapath) between NUM_REQ requesters. It owns the per-slave chip selects and applies each requester's polarity/phase mode. It sequences setup, transfer, burst hold and inter-frame gap timing, and returns received bytes or a timeout error. Sits between client FSMs and the single SPI master instance.

Parameters:
NUM_REQ, 4, number of requesters / chip selects (2..8)
SETUP_CYCLES, 2, clk cycles CS low before engine start (>=1)
GAP_CYCLES, 4, clk cycles CS high between frames (>=1)
TIMEOUT, 1023, max clk cycles from m_start to m_done before abort

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester transfer request, level
req_data  in  8*NUM_REQ  byte to send, slice i for requester i
req_mode  in  2*NUM_REQ  {polarity,phase} per requester
req_last  in  NUM_REQ  1 = this byte ends the frame (CS released after)
ack  out  NUM_REQ  one-cycle pulse: byte finished for requester i
err  out  1  valid with ack: 1 = timeout abort
rd_data  out  8  received byte, valid with ack
cs_n  out  NUM_REQ  chip selects, active low, one-hot-low or all high
m_start  out  1  one-cycle start pulse to byte engine
m_data_wr  out  8  byte to engine, stable from m_start to m_done
m_polarity  out  1  engine CPOL
m_phase  out  1  engine CPHA
m_done  in  1  engine one-cycle completion pulse
m_data_rd  in  8  engine received byte, valid with m_done
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, async): state IDLE, cs_n all 1, ack 0, err 0, rd_data 0, m_start 0, m_data_wr 0, m_polarity 0, m_phase 0, busy 0, rr pointer 0, counters 0.
- Requester contract: hold req/req_data/req_mode/req_last stable until ack; ack consumes the byte.
- States: IDLE, SETUP, START, WAIT, HOLD, GAP.
- IDLE: if any req, pick first set bit at or after rr pointer (wrapping); latch owner index, mode, data, last; drive cs_n[owner]=0; ->SETUP. Mode pins change only in IDLE.
- SETUP: count SETUP_CYCLES, then ->START.
- START: m_start=1 for exactly one cycle; clear timeout counter; ->WAIT.
- WAIT: on m_done: rd_data<=m_data_rd, ack[owner]=1 next cycle, err=0; if latched last=1 ->GAP else ->HOLD. If counter reaches TIMEOUT with no m_done: ack[owner]=1, err=1, rd_data=0, ->GAP.
- HOLD: CS stays low; ignore other requesters. If req[owner]=1 (earliest cycle after ack), latch new data/last, ->START (no SETUP). If req[owner]=0, ->GAP.
- GAP: cs_n all 1; count GAP_CYCLES; rr pointer <= owner+1 mod NUM_REQ; ->IDLE.
- Latency: IDLE req to m_start = SETUP_CYCLES+1 cycles; m_done to ack = 1 cycle.
- m_done outside WAIT is ignored. Simultaneous m_done and timeout: m_done wins.
- Requester dropping req mid-WAIT: transfer completes, ack still pulsed.
- rr pointer wraps NUM_REQ-1 -> 0; owner not re-granted until others served.

Decomposition:
- Package spi_pkg: state encoding localparams, mode encoding {CPOL,CPHA}, byte width 8.
- One sub-module: spi_rr_pick (combinational round-robin first-set-bit-from-pointer encoder, parameterised NUM_REQ).

Test Plan:
- Single byte: req[0], data 8'hA5, mode 2'b00, last=1 -> cs_n=4'b1110 for SETUP, one m_start, m_data_wr=A5; stub m_done with m_data_rd=3C -> ack[0], rd_data=3C, err=0, then cs_n=4'b1111 for 4 cycles.
- Round robin: req=4'b1011 held, every byte last=1 -> grant order 0,1,3,0,1,3; no two cs_n low at once.
- Burst: req[2] bytes 11,22,33, last on 33 -> cs_n[2] low throughout, 3 m_start pulses, SETUP only before first, gap after third.
- Mode: req[1] mode 2'b11 -> m_polarity=1, m_phase=1 from IDLE exit; mode change mid-burst ignored until next frame.
- Timeout: never pulse m_done -> ack with err=1, rd_data=00 after 1023 cycles, CS released, next requester served.
- Reset mid-WAIT: drop reset -> cs_n=4'b1111, m_start=0, busy=0 immediately; late m_done after release ignored.
